// File: rtl/trace_capture_if.sv
// trace_capture_if: sample stream into the capture block and logger stream out.
//   in_valid/in_time/in_data : emulator step sample (producer -> capture)
//   out_valid/out_ready      : FIFO head handshake (capture <-> logger)
//   out_time/out_data        : FIFO head entry fields
// Modports: master = producer/logger side, slave = trace_capture.
interface trace_capture_if #(
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [TIME_WIDTH-1:0] in_time;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [TIME_WIDTH-1:0] out_time;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_time, in_data, out_ready,
        input  out_valid, out_time, out_data
    );

    modport slave (
        input  in_valid, in_time, in_data, out_ready,
        output out_valid, out_time, out_data
    );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: arms on request, triggers on a rising zero crossing of the
// signed sample stream, keeps 1 of every decim+1 samples for CAP_LEN kept
// samples and queues {time, data} in a first-word fall-through FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : trace_capture_if.slave (sample in, FIFO head out)
//   arm        : level request to arm a capture
//   decim      : decimation factor (keep 1 of decim+1)
//   overflow   : sticky, a kept sample was dropped on a full FIFO
//   busy       : high whenever the controller is not idle
module trace_capture #(
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CAP_LEN    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trace_capture_if.slave       bus,
    input  logic                 arm,
    input  logic [7:0]           decim,
    output logic                 overflow,
    output logic                 busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CAP_LEN + 1);
    localparam int unsigned EW = TIME_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] LAST_KEEP = CW'(CAP_LEN - 1);
    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t          state;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [7:0]      dec_cnt;
    logic [CW-1:0]   kept_cnt;
    logic            prev_neg;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;

    logic empty, full, pop, cur_neg, trig, keep, push, drop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = !empty && bus.out_ready;
        cur_neg = bus.in_data[DATA_WIDTH-1];
        // arm=0 masks the trigger so a same-cycle disarm wins
        trig    = (state == ARMED) && arm && bus.in_valid && prev_neg && !cur_neg;
        keep    = trig || ((state == CAPTURE) && bus.in_valid && (dec_cnt == decim));
        // a full FIFO still accepts when its head leaves on the same edge
        push    = keep && (!full || pop);
        drop    = keep && !push;
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.out_valid = !empty;
    assign bus.out_time  = head[EW-1:DATA_WIDTH];
    assign bus.out_data  = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_time, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dec_cnt  <= '0;
            kept_cnt <= '0;
            prev_neg <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (bus.in_valid) prev_neg <= cur_neg;
            if (push)         wr_ptr   <= wr_ptr + PTR_ONE;
            if (pop)          rd_ptr   <= rd_ptr + PTR_ONE;
            if (drop)         overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= ARMED;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        kept_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (!arm) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (trig) begin
                        dec_cnt  <= '0;
                        kept_cnt <= CW'(1);
                        state    <= (CAP_LEN == 1) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.in_valid) begin
                        if (dec_cnt == decim) begin
                            dec_cnt  <= '0;
                            kept_cnt <= kept_cnt + CW'(1);
                            if (kept_cnt == LAST_KEEP) state <= DONE;
                        end else begin
                            dec_cnt <= dec_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (empty && !arm) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
